// File: rtl/counter_heap_pkg.sv
// Shared constants and helpers for the counter_heap_mp pattern-history store.
package counter_heap_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Saturation limits for a counter of the given width.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned sat_min(input int unsigned w);
    return (w == 0) ? 32'd0 : 32'd0;
  endfunction

  // LSB position of a lane within a packed multi-lane bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/counter_heap_mp_sat_next.sv
// Next-value function of one saturating counter: update first, then optional halving.
module counter_sat_next
  import counter_heap_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cur_val,
  input  logic         up_hit,
  input  logic         up_dir,
  input  logic         sweep_hit,
  output logic [W-1:0] nxt_val_c
);

  localparam logic [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W));

  logic [W-1:0] upd_val;

  always_comb begin
    upd_val = cur_val;
    if (up_hit) begin
      if (up_dir) begin
        if (cur_val != MAX_V) upd_val = cur_val + W'(1);
      end else if (cur_val != MIN_V) begin
        upd_val = cur_val - W'(1);
      end
    end
    nxt_val_c = sweep_hit ? (upd_val >> 1) : upd_val;
  end

endmodule

// File: rtl/counter_heap_mp.sv
// Multi-read-port saturating counter bank with write-first reads and attenuation.
// Define COUNTER_HEAP_FLASH_ATTEN_EN for single-cycle flash halving instead of the sweep FSM.
module counter_heap_mp
  import counter_heap_pkg::*;
#(
  parameter int unsigned COUNTERWIDE = 2,
  parameter int unsigned COUNTERPW   = 6,
  parameter int unsigned COUNTERDEEP = 64,
  parameter int unsigned READPORTS   = 2,
  parameter int unsigned INITVAL     = 1
) (
  input  logic                             Clk,
  input  logic                             Rest,
  input  logic [COUNTERPW-1:0]             UpAddr,
  input  logic                             UpdateAble,
  input  logic                             RightOrFault,
  input  logic [READPORTS*COUNTERPW-1:0]   ReadAddr,
  input  logic [READPORTS-1:0]             ReadAble,
  output logic [READPORTS*COUNTERWIDE-1:0] DoutCounter,
  input  logic                             Attenuation,
  output logic                             AttenBusy,
  output logic                             AttenDone
);

  logic [COUNTERWIDE-1:0]           cnt_q [COUNTERDEEP];
  logic [COUNTERWIDE-1:0]           cnt_d [COUNTERDEEP];
  logic [READPORTS*COUNTERWIDE-1:0] dout_q, dout_d;
  logic                             done_q, done_d;
  logic [COUNTERDEEP-1:0]           sweep_sel_c;

`ifdef COUNTER_HEAP_FLASH_ATTEN_EN
  // Flash mode: every entry halves in the cycle Attenuation is seen.
  always_comb begin
    sweep_sel_c = {COUNTERDEEP{Attenuation}};
    done_d      = Attenuation;
  end

  assign AttenBusy = 1'b0;
`else
  logic [0:0]           state_q, state_d;
  logic [COUNTERPW-1:0] ptr_q, ptr_d;

  // Sweep FSM: halves entry ptr_q each cycle, pulses done after the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Attenuation) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (ptr_q == COUNTERPW'(COUNTERDEEP - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + COUNTERPW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sweep_sel_c = '0;
    if (state_q == ST_SWEEP) sweep_sel_c[ptr_q] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign AttenBusy = (state_q == ST_SWEEP);
`endif

  for (genvar a = 0; a < COUNTERDEEP; a++) begin : g_entry
    counter_sat_next #(.W(COUNTERWIDE)) u_next (
      .cur_val   (cnt_q[a]),
      .up_hit    (UpdateAble && (UpAddr == COUNTERPW'(a))),
      .up_dir    (RightOrFault),
      .sweep_hit (sweep_sel_c[a]),
      .nxt_val_c (cnt_d[a])
    );
  end

  // Reads see this cycle's next value, so same-cycle updates and halving bypass.
  always_comb begin
    dout_d = '0;
    for (int unsigned k = 0; k < READPORTS; k++) begin
      if (ReadAble[k]) begin
        dout_d[lane_lsb(k, COUNTERWIDE) +: COUNTERWIDE] =
          cnt_d[ReadAddr[lane_lsb(k, COUNTERPW) +: COUNTERPW]];
      end
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      for (int unsigned i = 0; i < COUNTERDEEP; i++) cnt_q[i] <= COUNTERWIDE'(INITVAL);
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < COUNTERDEEP; i++) cnt_q[i] <= cnt_d[i];
      dout_q <= dout_d;
      done_q <= done_d;
    end
  end

  assign DoutCounter = dout_q;
  assign AttenDone   = done_q;

endmodule
